// File: rtl/myo_spi_pkg.sv
// Shared constants and types for the myocontrol SPI responder.
//   WORD_BITS  : bits per SPI word (fixed at 16)
//   state_t    : responder frame state
//   idx_width  : width of a word counter/index able to hold 0..frame_words
package myo_spi_pkg;

    localparam int WORD_BITS = 16;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        IDLE     = 2'd1,
        ACTIVE   = 2'd2,
        OVERRUN  = 2'd3
    } state_t;

    // Counter width for values 0..frame_words, never narrower than one bit.
    function automatic int idx_width(input int frame_words);
        int w;
        w = $clog2(frame_words + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/myo_spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous pin, with single-cycle rise and
// fall pulses derived from the synchronised value and a one-cycle delayed copy.
// All flops reset to 0 so that a high pin after reset is seen as a fresh rise.
//   clk, reset_n : system clock, async active-low reset
//   din          : asynchronous pin
//   sync         : synchronised level
//   rise, fall   : one-cycle pulses on synchronised transitions
module myo_spi_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic dly_r;

    // Synchroniser chain plus the delayed copy used for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            dly_r  <= 1'b0;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            dly_r  <= sync_r;
        end
    end

    assign sync = sync_r;
    assign rise = sync_r & ~dly_r;
    assign fall = ~sync_r & dly_r;

endmodule

// File: rtl/myo_spi_responder.sv
// SPI responder (mode 0, MSB first) for the motor-board end of the myocontrol
// link. Pins are oversampled in the clk domain (SCK <= clk/8). Each frame
// returns a snapshot of tx_words taken at select, and delivers received words.
//   clk, reset_n       : system clock, async active-low reset
//   sck, ss_n, mosi    : SPI pins from the master (asynchronous)
//   miso, miso_oe      : responder data and its tri-state enable
//   tx_words           : status words, word k at [16k+15:16k]
//   rx_word/rx_index   : last received word and its position, with rx_valid
//   cmd                : word 0 of the last correctly sized frame
//   frame_done/ok      : end-of-frame pulse and length-correct flag
module myo_spi_responder
    import myo_spi_pkg::*;
#(
    parameter  int FRAME_WORDS = 4,
    localparam int IDX_W       = idx_width(FRAME_WORDS)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             sck,
    input  logic                             ss_n,
    input  logic                             mosi,
    output logic                             miso,
    output logic                             miso_oe,
    input  logic [FRAME_WORDS*WORD_BITS-1:0] tx_words,
    output logic [WORD_BITS-1:0]             rx_word,
    output logic [IDX_W-1:0]                 rx_index,
    output logic                             rx_valid,
    output logic [WORD_BITS-1:0]             cmd,
    output logic                             frame_done,
    output logic                             frame_ok
);

    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(FRAME_WORDS);

    // Synchronised pins and edges
    logic       sck_rise_s, sck_fall_s;
    logic       ss_sync_s, ss_rise_s, ss_fall_s;
    logic       mosi_sync_s;
    logic [2:0] sync_unused_s;

    // FSM
    state_t state_r, state_s;

    // Decoded controls
    logic in_frame_s, start_s, stop_s;
    logic sck_rise_q_s, sck_fall_q_s;
    logic wrap_s, overrun_s, frame_good_s;

    // Datapath
    logic [3:0]                       bit_cnt_r;
    logic [IDX_W-1:0]                 word_cnt_r;
    logic [IDX_W-1:0]                 done_idx_r;
    logic                             word_done_r;
    logic [WORD_BITS-1:0]             rx_shift_r;
    logic [WORD_BITS-1:0]             tx_shift_r;
    logic [FRAME_WORDS*WORD_BITS-1:0] shadow_r;
    logic [WORD_BITS-1:0]             word0_r;
    logic [IDX_W:0]                   next_idx_s;
    logic [WORD_BITS-1:0]             next_word_s;
    logic                             end_pend_r;
    logic                             ok_pend_r;

    // Output registers
    logic                 miso_r, miso_oe_r;
    logic [WORD_BITS-1:0] rx_word_r, cmd_r;
    logic [IDX_W-1:0]     rx_index_r;
    logic                 rx_valid_r, frame_done_r, frame_ok_r;

    myo_spi_sync_edge u_sck_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sck),
        .sync    (sync_unused_s[0]),
        .rise    (sck_rise_s),
        .fall    (sck_fall_s)
    );

    myo_spi_sync_edge u_ss_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (ss_n),
        .sync    (ss_sync_s),
        .rise    (ss_rise_s),
        .fall    (ss_fall_s)
    );

    myo_spi_sync_edge u_mosi_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (mosi),
        .sync    (mosi_sync_s),
        .rise    (sync_unused_s[1]),
        .fall    (sync_unused_s[2])
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= DISARMED;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; DISARMED waits for a deselected bus so a frame already
    // in progress at reset release is never joined
    always_comb begin
        state_s = state_r;
        case (state_r)
            DISARMED: begin
                if (ss_sync_s) state_s = IDLE;
                else           state_s = DISARMED;
            end
            IDLE: begin
                if (ss_fall_s) state_s = ACTIVE;
                else           state_s = IDLE;
            end
            ACTIVE: begin
                if (ss_rise_s)      state_s = IDLE;
                else if (overrun_s) state_s = OVERRUN;
                else                state_s = ACTIVE;
            end
            OVERRUN: begin
                if (ss_rise_s) state_s = IDLE;
                else           state_s = OVERRUN;
            end
            default: state_s = DISARMED;
        endcase
    end

    // Control decode; sck edges count only while selected, so an ss_n rise
    // coinciding with an sck edge ends the frame and the edge is dropped
    always_comb begin
        in_frame_s   = (state_r == ACTIVE) || (state_r == OVERRUN);
        start_s      = (state_r == IDLE) && ss_fall_s;
        stop_s       = in_frame_s && ss_rise_s;
        sck_rise_q_s = in_frame_s && !ss_sync_s && sck_rise_s;
        sck_fall_q_s = in_frame_s && !ss_sync_s && sck_fall_s;
        wrap_s       = sck_rise_q_s && (state_r == ACTIVE) && (bit_cnt_r == 4'd15);
        overrun_s    = wrap_s && (word_cnt_r == LAST_CNT);
        frame_good_s = (state_r == ACTIVE) && (bit_cnt_r == 4'd0) && (word_cnt_r == LAST_CNT);
    end

    // Select the shadow word following the one just completed, zero past the end
    always_comb begin
        next_idx_s  = {1'b0, word_cnt_r} + (IDX_W+1)'(1);
        next_word_s = {WORD_BITS{1'b0}};
        for (int k = 0; k < FRAME_WORDS; k++) begin
            if (next_idx_s == (IDX_W+1)'(k)) begin
                next_word_s = shadow_r[k*WORD_BITS +: WORD_BITS];
            end else begin
                next_word_s = next_word_s;
            end
        end
    end

    // Bit/word counters; a completed word is flagged for release next cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_r   <= 4'd0;
            word_cnt_r  <= {IDX_W{1'b0}};
            done_idx_r  <= {IDX_W{1'b0}};
            word_done_r <= 1'b0;
        end else if (start_s) begin
            bit_cnt_r   <= 4'd0;
            word_cnt_r  <= {IDX_W{1'b0}};
            done_idx_r  <= done_idx_r;
            word_done_r <= 1'b0;
        end else begin
            if (sck_rise_q_s) begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
            end
            if (wrap_s && !overrun_s) begin
                word_cnt_r <= word_cnt_r + IDX_W'(1);
                done_idx_r <= word_cnt_r;
            end
            word_done_r <= wrap_s && !overrun_s;
        end
    end

    // Receive shifter, MSB first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_shift_r <= {WORD_BITS{1'b0}};
        end else if (sck_rise_q_s) begin
            rx_shift_r <= {rx_shift_r[WORD_BITS-2:0], mosi_sync_s};
        end else begin
            rx_shift_r <= rx_shift_r;
        end
    end

    // Transmit path: snapshot at select, MSB out immediately, next bit on each
    // sck fall; tx_shift holds the bits not yet presented
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_r   <= {(FRAME_WORDS*WORD_BITS){1'b0}};
            tx_shift_r <= {WORD_BITS{1'b0}};
            miso_r     <= 1'b0;
            miso_oe_r  <= 1'b0;
        end else if (start_s) begin
            shadow_r   <= tx_words;
            tx_shift_r <= {tx_words[WORD_BITS-2:0], 1'b0};
            miso_r     <= tx_words[WORD_BITS-1];
            miso_oe_r  <= 1'b1;
        end else if (end_pend_r) begin
            miso_r     <= 1'b0;
            miso_oe_r  <= 1'b0;
        end else if (overrun_s) begin
            tx_shift_r <= {WORD_BITS{1'b0}};
            miso_r     <= 1'b0;
        end else if (wrap_s) begin
            tx_shift_r <= next_word_s;
        end else if (sck_fall_q_s) begin
            miso_r     <= (state_r == OVERRUN) ? 1'b0 : tx_shift_r[WORD_BITS-1];
            tx_shift_r <= {tx_shift_r[WORD_BITS-2:0], 1'b0};
        end else begin
            tx_shift_r <= tx_shift_r;
        end
    end

    // Word/frame result registers; frame end is reported one cycle after the
    // state returns to IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            end_pend_r   <= 1'b0;
            ok_pend_r    <= 1'b0;
            word0_r      <= {WORD_BITS{1'b0}};
            rx_valid_r   <= 1'b0;
            rx_word_r    <= {WORD_BITS{1'b0}};
            rx_index_r   <= {IDX_W{1'b0}};
            frame_done_r <= 1'b0;
            frame_ok_r   <= 1'b0;
            cmd_r        <= {WORD_BITS{1'b0}};
        end else begin
            end_pend_r   <= stop_s;
            ok_pend_r    <= stop_s && frame_good_s;
            rx_valid_r   <= word_done_r;
            frame_done_r <= end_pend_r;
            frame_ok_r   <= end_pend_r && ok_pend_r;
            if (word_done_r) begin
                rx_word_r  <= rx_shift_r;
                rx_index_r <= done_idx_r;
            end
            if (word_done_r && (done_idx_r == {IDX_W{1'b0}})) begin
                word0_r <= rx_shift_r;
            end
            if (end_pend_r && ok_pend_r) begin
                cmd_r <= word0_r;
            end
        end
    end

    assign miso       = miso_r;
    assign miso_oe    = miso_oe_r;
    assign rx_word    = rx_word_r;
    assign rx_index   = rx_index_r;
    assign rx_valid   = rx_valid_r;
    assign cmd        = cmd_r;
    assign frame_done = frame_done_r;
    assign frame_ok   = frame_ok_r;

endmodule

// File: tb/tb_myo_spi_responder.sv
// Scoreboard bench for myo_spi_responder (FRAME_WORDS=4), master at clk/8.
module tb_myo_spi_responder;

    localparam int HALF = 40;   // half SCK period = 4 clk

    logic        clk = 1'b0;
    logic        reset_n, sck, ss_n, mosi;
    logic        miso, miso_oe, rx_valid, frame_done, frame_ok;
    logic [63:0] tx_words;
    logic [15:0] rx_word, cmd;
    logic [2:0]  rx_index;

    typedef struct { logic [15:0] word; logic [2:0] idx; } rx_exp_t;
    typedef struct { logic ok; logic [15:0] cmd; } fr_exp_t;

    rx_exp_t     rx_q[$];
    fr_exp_t     fr_q[$];
    logic [15:0] mosi_words[8];
    logic [15:0] got[8];
    logic [15:0] exp_cmd;
    int          checks = 0;
    int          failures = 0;

    myo_spi_responder #(.FRAME_WORDS(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sck        (sck),
        .ss_n       (ss_n),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .tx_words   (tx_words),
        .rx_word    (rx_word),
        .rx_index   (rx_index),
        .rx_valid   (rx_valid),
        .cmd        (cmd),
        .frame_done (frame_done),
        .frame_ok   (frame_ok)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop expectations as the DUT reports words and frame ends
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (rx_valid) begin
                if (rx_q.size() == 0) begin
                    check_eq("rx_unexpected", 32'(rx_q.size()), 32'd1);
                end else begin
                    rx_exp_t e;
                    e = rx_q.pop_front();
                    check_eq("rx_word", 32'(rx_word), 32'(e.word));
                    check_eq("rx_index", 32'(rx_index), 32'(e.idx));
                end
            end
            if (frame_done) begin
                if (fr_q.size() == 0) begin
                    check_eq("frame_unexpected", 32'(fr_q.size()), 32'd1);
                end else begin
                    fr_exp_t f;
                    f = fr_q.pop_front();
                    check_eq("frame_ok", 32'(frame_ok), 32'(f.ok));
                    check_eq("cmd", 32'(cmd), 32'(f.cmd));
                end
            end
        end
    end

    task automatic spi_xfer(input int nbits, input bit end_frame);
        for (int w = 0; w < 8; w++) got[w] = 16'h0000;
        ss_n = 1'b0;
        mosi = mosi_words[0][15];
        #(HALF);
        for (int b = 0; b < nbits; b++) begin
            sck = 1'b1;
            got[b/16][15 - (b%16)] = miso;
            #(HALF);
            sck = 1'b0;
            if (b + 1 < nbits) mosi = mosi_words[(b+1)/16][15 - ((b+1)%16)];
            #(HALF);
        end
        if (end_frame) begin
            check_eq("miso_oe_on", 32'(miso_oe), 32'd1);
            ss_n = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            check_eq("miso_oe_off", 32'(miso_oe), 32'd0);
            repeat (8) @(posedge clk);
        end
    endtask

    // Push expectations, run one frame at a random phase, compare miso words
    task automatic do_frame(input int nbits, input bit end_frame);
        logic [63:0] snap;
        logic [15:0] want;
        int          nw;
        nw = nbits / 16;
        for (int w = 0; w < nw && w < 4; w++) rx_q.push_back('{word: mosi_words[w], idx: 3'(w)});
        if (end_frame) begin
            if (nbits == 64) exp_cmd = mosi_words[0];
            fr_q.push_back('{ok: (nbits == 64), cmd: exp_cmd});
        end
        @(posedge clk);
        #($urandom_range(1, 9));
        snap = tx_words;
        spi_xfer(nbits, end_frame);
        for (int w = 0; w < nw; w++) begin
            want = (w < 4) ? snap[w*16 +: 16] : 16'h0000;
            check_eq($sformatf("miso_w%0d", w), 32'(got[w]), 32'(want));
        end
    endtask

    task automatic sck_only(input int n);
        for (int i = 0; i < n; i++) begin
            mosi = 1'($urandom_range(0, 1));
            sck = 1'b1;
            #(HALF);
            sck = 1'b0;
            #(HALF);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        sck      = 1'b0;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        exp_cmd  = 16'h0000;
        tx_words = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_miso", 32'(miso), 32'd0);
        check_eq("rst_miso_oe", 32'(miso_oe), 32'd0);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_rx_word", 32'(rx_word), 32'd0);
        check_eq("rst_cmd", 32'(cmd), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(posedge clk);

        // Good frame
        mosi_words[0] = 16'hA5A5; mosi_words[1] = 16'h0001;
        mosi_words[2] = 16'h0002; mosi_words[3] = 16'h0003;
        do_frame(64, 1'b1);

        // Aborted after 2 words + 5 bits
        mosi_words[0] = 16'h1234; mosi_words[1] = 16'h5678; mosi_words[2] = 16'h9ABC;
        do_frame(37, 1'b1);

        // Six-word overrun frame
        for (int w = 0; w < 6; w++) mosi_words[w] = 16'h1000 + 16'(w * 16'h0111);
        do_frame(96, 1'b1);

        // Snapshot: tx changes mid-frame, next frame sees the new words
        for (int w = 0; w < 4; w++) mosi_words[w] = 16'hC000 | 16'(w);
        fork
            do_frame(64, 1'b1);
            begin #1000; tx_words = {64{1'b1}}; end
        join
        for (int w = 0; w < 4; w++) mosi_words[w] = 16'h0F00 | 16'(w);
        do_frame(64, 1'b1);

        // Reset mid-frame with ss_n still low
        for (int w = 0; w < 4; w++) mosi_words[w] = 16'h7E00 | 16'(w);
        do_frame(20, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        exp_cmd = 16'h0000;
        #1;
        check_eq("mid_rst_miso_oe", 32'(miso_oe), 32'd0);
        check_eq("mid_rst_miso", 32'(miso), 32'd0);
        check_eq("mid_rst_cmd", 32'(cmd), 32'(exp_cmd));
        check_eq("mid_rst_rx_word", 32'(rx_word), 32'd0);
        check_eq("mid_rst_frame_ok", 32'(frame_ok), 32'd0);
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b1;
        sck_only(16);
        check_eq("disarmed_miso_oe", 32'(miso_oe), 32'd0);
        ss_n = 1'b1;
        repeat (10) @(posedge clk);
        for (int w = 0; w < 4; w++) mosi_words[w] = 16'h3C00 | 16'(w);
        do_frame(64, 1'b1);

        // sck activity while deselected, then random data at random phase
        sck_only(32);
        check_eq("idle_miso_oe", 32'(miso_oe), 32'd0);
        tx_words = {32'($urandom), 32'($urandom)};
        for (int w = 0; w < 4; w++) mosi_words[w] = 16'($urandom);
        do_frame(64, 1'b1);

        repeat (10) @(posedge clk);
        check_eq("rx_q_left", 32'(rx_q.size()), 32'd0);
        check_eq("fr_q_left", 32'(fr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/myo_spi_responder.md
Name: myo_spi_responder

Overview:
SPI responder (slave) for the motor-board end of the myocontrol SPI link: it answers frames issued by the myocontrol master (sck/mosi/miso/ss_n).
- Used as an FPGA-side muscle-unit emulator and as a loopback target for testing the master.
- Receives 16-bit command words and returns a per-frame snapshot of status words.
- Oversamples the SPI pins in the system clock domain.

Parameters:
FRAME_WORDS, 4, number of 16-bit words per valid frame (must be >= 1)
WORD_BITS, 16, bits per word (fixed at 16; parameterised only for the package constant)

Ports:
clk  input  1  system clock; SCK must be <= clk/8
reset_n  input  1  asynchronous active-low reset
sck  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0), asynchronous to clk
ss_n  input  1  active-low select, asynchronous
mosi  input  1  master-out data, MSB first
miso  output  1  responder-out data, MSB first
miso_oe  output  1  tri-state enable for shared miso (1 = drive)
tx_words  input  FRAME_WORDS*16  status words; word k at bits [16k+15:16k]
rx_word  output  16  last received word
rx_index  output  clog2(FRAME_WORDS+1)  index of rx_word within the frame
rx_valid  output  1  one-cycle pulse: rx_word/rx_index updated
cmd  output  16  word 0 of the last good frame
frame_done  output  1  one-cycle pulse at frame end
frame_ok  output  1  valid with frame_done: frame length was correct

Behaviour:
- Reset (async assert, sync release): all outputs 0; miso_oe=0; state DISARMED.
- Synchronisation and edge detection:
  - sck, ss_n and mosi each pass through 2-FF synchronisers.
  - Edge detection compares the synchronised value against a one-cycle delayed copy.
- States:
  - DISARMED -> IDLE when synchronised ss_n=1. This prevents joining a frame already in progress after reset.
  - IDLE -> ACTIVE on ss_n falling edge. In that cycle:
    - snapshot tx_words into the shadow bank;
    - bit_cnt=0, word_cnt=0;
    - miso = shadow word 0 bit 15;
    - miso_oe=1.
  - ACTIVE:
    - On sck rising: shift the synchronised mosi into rx_shift; bit_cnt++.
    - On sck falling: present the next tx bit on miso.
    - When bit_cnt wraps 15 -> 0 after the 16th rising edge:
      - next cycle: rx_word=rx_shift, rx_index=word_cnt, rx_valid=1;
      - word_cnt++;
      - the tx shifter loads shadow word word_cnt+1, or 0x0000 if that index >= FRAME_WORDS.
  - ACTIVE -> OVERRUN when word_cnt would exceed FRAME_WORDS. In OVERRUN:
    - miso=0 and stays driven;
    - rx_valid is suppressed;
    - the state is held until ss_n rises.
  - ACTIVE/OVERRUN -> IDLE on ss_n rising edge. Next cycle:
    - frame_done=1;
    - frame_ok=1 iff state was ACTIVE and bit_cnt==0 and word_cnt==FRAME_WORDS;
    - if frame_ok, cmd = word 0 of this frame (kept in a word-0 capture register);
    - miso_oe=0.
- Latency:
  - rx_valid is asserted 4 clk after the pin-level 16th sck rising edge (2 sync + 1 edge + 1 register).
  - frame_done is asserted 4 clk after the ss_n pin rise.
- The first miso bit is valid within 3 clk of the ss_n pin fall. The master must allow >= half an SCK period before its first rising edge.
- Simultaneous events:
  - An ss_n rise in the same cycle as a sck edge: the ss_n rise wins and the edge is ignored.
  - sck edges while ss_n is high are ignored in all states.
- Aborted frames:
  - A partial word (bit_cnt != 0 at ss_n rise) is discarded without rx_valid; frame_ok=0.
  - A short frame (word_cnt < FRAME_WORDS) gives frame_ok=0; cmd is unchanged.
- Snapshot: tx_words changes during a frame do not affect that frame.
- Reset mid-frame: immediate return to DISARMED with outputs 0. The interrupted frame produces no frame_done.

Decomposition:
- Package myo_spi_pkg:
  - WORD_BITS=16;
  - state enum {DISARMED, IDLE, ACTIVE, OVERRUN};
  - function idx_width(FRAME_WORDS).
- Sub-module myo_spi_sync_edge: 2-FF synchroniser plus rise/fall pulse generation, instantiated three times. Only the sck and ss_n instances use the edge outputs.

Test Plan:
- FRAME_WORDS=4, tx_words={0x4444,0x3333,0x2222,0x1111}, master sends 0xA5A5,0x0001,0x0002,0x0003 at clk/8 -> miso returns 0x1111,0x2222,0x3333,0x4444; rx_valid x4 with indices 0..3; frame_done with frame_ok=1; cmd=0xA5A5.
- ss_n raised after 2 words + 5 bits -> rx_valid x2 only, frame_done with frame_ok=0, cmd unchanged, miso_oe=0 within 4 clk.
- 6-word frame -> words 4,5 read miso=0x0000, no rx_valid for words 4,5, frame_ok=0.
- tx_words changed to all 0xFFFF mid-frame -> the current frame still returns the original snapshot; the next frame returns 0xFFFF.
- reset_n pulsed low mid-frame with ss_n still low -> outputs 0, no frame_done; following sck edges ignored until ss_n high, then the next frame is good.
- sck toggling with ss_n high, and SCK at exactly clk/8 with random phase -> no rx_valid while ss_n high; bit-exact data at clk/8.
